// File: rtl/snap_pkg.sv
// snap_pkg: shared FSM states and default sizes for the count snapshot serializer
package snap_pkg;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR, S_DONE} snap_state_e;

    localparam int SNAP_WIDTH       = 8;
    localparam int SNAP_DIV_DEFAULT = 4;

    // True in the states where a bit is on the wire and ser_cs_n is low
    function automatic logic is_framing(snap_state_e s);
        return (s == S_SHIFT) || (s == S_PAR);
    endfunction

endpackage

// File: rtl/snap_bit_timer.sv
// snap_bit_timer: divides clk into serial bit periods and produces the ser_clk phase
module snap_bit_timer #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic run_i,
    input  logic run_next_i,
    output logic bit_end_o,
    output logic ser_clk_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          ser_clk_q, ser_clk_d;

    assign bit_end_o = run_i && (div_cnt_q == CW'(DIV - 1));
    assign ser_clk_o = ser_clk_q;

    // Count through one bit period; ser_clk is registered from the next count so it is flop-driven
    always_comb begin
        div_cnt_d = (clr_i || !run_i || bit_end_o) ? '0 : div_cnt_q + CW'(1);
        ser_clk_d = run_next_i && (div_cnt_d >= CW'(DIV / 2));
    end

    // Divider and serial clock state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
            ser_clk_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            ser_clk_q <= ser_clk_d;
        end
    end

endmodule

// File: rtl/count_snapshot_tx.sv
// count_snapshot_tx: captures the live count and shifts it out MSB-first on a 3-wire link (parity bit with SNAP_PARITY_EN)
module count_snapshot_tx
    import snap_pkg::*;
#(
    parameter int DIV   = SNAP_DIV_DEFAULT,
    parameter int WIDTH = SNAP_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] count_in,
    input  logic             snap_req,
    input  logic             ovr_clr,
    output logic             ser_cs_n,
    output logic             ser_clk,
    output logic             ser_data,
    output logic             busy,
    output logic             done,
    output logic             overrun
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    snap_state_e      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]    bit_idx_q, bit_idx_d;
    logic             ser_data_q, ser_data_d;
    logic             overrun_q, overrun_d;
    logic             cs_n_q, busy_q, done_q;
    logic             bit_end, capture, last_bit;
`ifdef SNAP_PARITY_EN
    logic             par_q;
`endif

    assign capture  = (state_q == S_IDLE) && snap_req;
    assign last_bit = bit_idx_q == BW'(WIDTH - 1);

    snap_bit_timer #(.DIV(DIV)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (capture),
        .run_i      (is_framing(state_q)),
        .run_next_i (is_framing(state_d)),
        .bit_end_o  (bit_end),
        .ser_clk_o  (ser_clk)
    );

    // Frame sequencing; shreg holds the bits still to be sent, so the MSB is driven at capture
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        ser_data_d = ser_data_q;
        overrun_d  = (snap_req && state_q != S_IDLE) || (overrun_q && !ovr_clr);
        case (state_q)
            S_IDLE: if (snap_req) begin
                state_d    = S_SHIFT;
                shreg_d    = count_in << 1;
                bit_idx_d  = '0;
                ser_data_d = count_in[WIDTH-1];
            end
            S_SHIFT: if (bit_end) begin
                if (!last_bit) begin
                    shreg_d    = shreg_q << 1;
                    ser_data_d = shreg_q[WIDTH-1];
                    bit_idx_d  = bit_idx_q + BW'(1);
                end else begin
`ifdef SNAP_PARITY_EN
                    state_d    = S_PAR;
                    ser_data_d = par_q;
`else
                    state_d    = S_DONE;
                    ser_data_d = 1'b0;
`endif
                end
            end
`ifdef SNAP_PARITY_EN
            S_PAR: if (bit_end) begin
                state_d    = S_DONE;
                ser_data_d = 1'b0;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and flop-driven outputs; outputs follow the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            ser_data_q <= 1'b0;
            overrun_q  <= 1'b0;
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            ser_data_q <= ser_data_d;
            overrun_q  <= overrun_d;
            cs_n_q     <= !is_framing(state_d);
            busy_q     <= state_d != S_IDLE;
            done_q     <= state_d == S_DONE;
        end
    end

`ifdef SNAP_PARITY_EN
    // Even parity of the captured word, frozen for the whole frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            par_q <= 1'b0;
        else if (capture)
            par_q <= ^count_in;
    end
`endif

    assign ser_cs_n = cs_n_q;
    assign ser_data = ser_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_count_snapshot_tx.sv
// tb_count_snapshot_tx: directed and random frames checked against a receiver-side model
module tb_count_snapshot_tx;
  localparam int DIV = 4;
  localparam int W   = 8;
`ifdef SNAP_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [W-1:0] count_in = '0;
  logic         snap_req = 1'b0;
  logic         ovr_clr = 1'b0;
  logic         ser_cs_n, ser_clk, ser_data, busy, done, overrun;
  int checks = 0;
  int failures = 0;
  count_snapshot_tx #(.DIV(DIV), .WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .count_in (count_in),
    .snap_req (snap_req),
    .ovr_clr  (ovr_clr),
    .ser_cs_n (ser_cs_n),
    .ser_clk  (ser_clk),
    .ser_data (ser_data),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] exp_word(input logic [W-1:0] v);
`ifdef SNAP_PARITY_EN
    return {7'd0, v, ^v};
`else
    return {8'd0, v};
`endif
  endfunction
  task automatic mon(input int act, input int k, input logic [W-1:0] av, input bit hold,
                     output logic [15:0] rx, output int nb, output int csl, output int bh,
                     output int dc, output int dn, output int fb, output int stab, output bit to);
    logic pclk, pdat;
    rx = '0; nb = 0; csl = 0; bh = 0; dc = 0; dn = 0; fb = 0; stab = 0; to = 1'b1;
    pclk = 1'b0; pdat = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        fb = int'(busy);
        if (!hold) snap_req = 1'b0;
      end
      if (ser_clk && !pclk) begin
        rx = {rx[14:0], ser_data};
        nb++;
      end
      if (c > 1 && ser_data !== pdat && ser_clk) stab++;
      pclk = ser_clk;
      pdat = ser_data;
      csl += int'(!ser_cs_n);
      bh  += int'(busy);
      if (done) begin
        dn++;
        dc = c;
      end
      if (c == k && act == 1) count_in = av;
      if (c == k && act == 2) snap_req = 1'b1;
      if (c == k && act == 3) begin
        snap_req = 1'b1;
        ovr_clr  = 1'b1;
      end
      if (c == k + 1 && act >= 2) begin
        snap_req = 1'b0;
        ovr_clr  = 1'b0;
      end
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask
  task automatic frame(input string tag, input logic [W-1:0] v, input bit start, input int act,
                       input int k, input logic [W-1:0] av, input bit hold);
    logic [15:0] rx;
    int nb, csl, bh, dc, dn, fb, stab;
    bit to;
    if (start) begin
      count_in = v;
      snap_req = 1'b1;
    end
    mon(act, k, av, hold, rx, nb, csl, bh, dc, dn, fb, stab, to);
    chk({tag, "/timeout"}, to, 1'b0);
    chk({tag, "/word"}, rx, exp_word(v));
    chk({tag, "/nbits"}, nb, NB);
    chk({tag, "/cs_low"}, csl, NB * DIV);
    chk({tag, "/busy_len"}, bh, NB * DIV + 1);
    chk({tag, "/done_cyc"}, dc, NB * DIV + 1);
    chk({tag, "/done_cnt"}, dn, 1);
    chk({tag, "/first_busy"}, fb, 1);
    chk({tag, "/data_stable"}, stab, 0);
  endtask
  initial begin
    int dseen;
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("reset_outs", {ser_cs_n, ser_clk, ser_data, busy, done, overrun}, 6'b100000);
    rst_n = 1'b1;
    @(negedge clk);
    frame("a5", 8'hA5, 1'b1, 0, 0, 8'h00, 1'b0);
    frame("07", 8'h07, 1'b1, 0, 0, 8'h00, 1'b0);
    frame("mid_change", 8'h3C, 1'b1, 1, 5, 8'hFF, 1'b0);
    chk("ovr_idle", overrun, 1'b0);
    frame("ovr_req", 8'h96, 1'b1, 2, 10, 8'h00, 1'b0);
    chk("ovr_set", overrun, 1'b1);
    frame("ovr_both", 8'h4E, 1'b1, 3, 10, 8'h00, 1'b0);
    chk("ovr_set_wins", overrun, 1'b1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 1'b0);
    frame("b2b_first", 8'h00, 1'b1, 1, 5, 8'h01, 1'b1);
    chk("b2b_ovr", overrun, 1'b1);
    frame("b2b_second", 8'h01, 1'b0, 0, 0, 8'h00, 1'b0);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    for (int i = 0; i < 5; i++)
      frame($sformatf("rand%0d", i), W'($urandom_range(0, 255)), 1'b1, 0, 0, 8'h00, 1'b0);
    count_in = 8'h5A;
    snap_req = 1'b1;
    @(negedge clk);
    snap_req = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst_busy", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {ser_cs_n, ser_clk, ser_data, busy, done, overrun}, 6'b100000);
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      dseen += int'(done);
    end
    chk("rst_no_done", dseen, 0);
    rst_n = 1'b1;
    @(negedge clk);
    frame("post_rst", 8'hC3, 1'b1, 0, 0, 8'h00, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
